// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the req/ack handshake to
// instruction memory, holds the fetched word for the decoder, resolves the
// next PC from branch/jump flags and counts retired instructions.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        ex_done,
  input  logic        beq_flag,
  input  logic        bne_flag,
  input  logic        jump,
  input  logic        zero,
  input  logic [31:0] imm_ext,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pcReg;
  logic [31:0] instrReg;
  logic [31:0] instretReg;
  logic        reqReg;
  logic        validReg;
  logic [31:0] pcPlus4;
  logic [31:0] nextPc;
  logic        branchTaken;

  // Sequential adder and decoder fields derive purely from held registers
  assign pcPlus4     = pcReg + 32'd4;
  assign branchTaken = (beq_flag & zero) | (bne_flag & ~zero);

  // Next-PC selection; jump outranks any branch
  always_comb begin
    nextPc = pcPlus4;
    if (jump) begin
      nextPc = {pcPlus4[31:28], instrReg[25:0], 2'b00};
    end else if (branchTaken) begin
      nextPc = pcPlus4 + {imm_ext[29:0], 2'b00};
    end
  end

  // Fetch/issue control, PC, held instruction and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pcReg      <= RESET_PC;
      instrReg   <= 32'd0;
      instretReg <= 32'd0;
      reqReg     <= 1'b0;
      validReg   <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state  <= FETCH;
          reqReg <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            instrReg <= imem_rdata;
            validReg <= 1'b1;
            reqReg   <= 1'b0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (ex_done) begin
            pcReg      <= nextPc;
            validReg   <= 1'b0;
            instretReg <= instretReg + 32'd1;
            reqReg     <= 1'b1;
            state      <= FETCH;
          end
        end
        default: begin
          state    <= BOOT;
          reqReg   <= 1'b0;
          validReg <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = reqReg;
  assign imem_addr   = pcReg;
  assign instr       = instrReg;
  assign op          = instrReg[31:26];
  assign funct       = instrReg[5:0];
  assign instr_valid = validReg;
  assign pc          = pcReg;
  assign pc_plus4    = pcPlus4;
  assign instret     = instretReg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scoreboard of expected fetched words
// and expected next-PC values.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        ex_done;
  logic        beq_flag;
  logic        bne_flag;
  logic        jump;
  logic        zero;
  logic [31:0] imm_ext;
  logic [31:0] instret;

  int nCmp = 0;
  int nMis = 0;

  logic [31:0] instrQ[$];
  logic [31:0] pcQ[$];
  logic [31:0] modelPc;
  logic [31:0] modelInstret;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .op(op), .funct(funct), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4),
    .ex_done(ex_done), .beq_flag(beq_flag), .bne_flag(bne_flag),
    .jump(jump), .zero(zero), .imm_ext(imm_ext), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop if the directed sequence ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nMis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] modelNext(input logic [31:0] p, input logic [31:0] ins,
                                            input logic [31:0] im, input logic j,
                                            input logic bq, input logic bn, input logic z);
    logic [31:0] p4;
    p4 = p + 32'd4;
    if (j) return {p4[31:28], ins[25:0], 2'b00};
    if ((bq && z) || (bn && !z)) return p4 + (im << 2);
    return p4;
  endfunction

  task automatic popInstr(input string tag);
    logic [31:0] e;
    if (instrQ.size() == 0) begin
      chk({tag, "_instrq_empty"}, 32'd0, 32'd1);
    end else begin
      e = instrQ.pop_front();
      chk(tag, instr, e);
    end
  endtask

  task automatic popPc(input string tag);
    logic [31:0] e;
    if (pcQ.size() == 0) begin
      chk({tag, "_pcq_empty"}, 32'd0, 32'd1);
    end else begin
      e = pcQ.pop_front();
      chk(tag, pc, e);
    end
  endtask

  // One full instruction from FETCH: ack immediately, then retire with flags
  task automatic doInstr(input string tag, input logic [31:0] word, input logic j,
                         input logic bq, input logic bn, input logic z,
                         input logic [31:0] im);
    chk({tag, "_addr"}, imem_addr, modelPc);
    chk({tag, "_req"}, 32'(imem_req), 32'd1);
    imem_ack = 1'b1;
    imem_rdata = word;
    instrQ.push_back(word);
    tick();
    imem_ack = 1'b0;
    imem_rdata = 32'hBAD0_BAD0;
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    popInstr({tag, "_instr"});
    jump = j; beq_flag = bq; bne_flag = bn; zero = z; imm_ext = im;
    ex_done = 1'b1;
    modelPc = modelNext(modelPc, word, im, j, bq, bn, z);
    modelInstret = modelInstret + 32'd1;
    pcQ.push_back(modelPc);
    tick();
    ex_done = 1'b0;
    jump = 1'b0; beq_flag = 1'b0; bne_flag = 1'b0; zero = 1'b0; imm_ext = 32'd0;
    popPc({tag, "_pc"});
    chk({tag, "_instret"}, instret, modelInstret);
    chk({tag, "_req_after"}, 32'(imem_req), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'd0; ex_done = 1'b0;
    beq_flag = 1'b0; bne_flag = 1'b0; jump = 1'b0; zero = 1'b0; imm_ext = 32'd0;
    modelPc = 32'd0;
    modelInstret = 32'd0;

    // 1: reset state and boot cycle
    repeat (3) tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_instr", instr, 32'd0);
    rst_n = 1'b1;
    imem_ack = 1'b1;
    chk("boot_req", 32'(imem_req), 32'd0);
    tick();
    imem_ack = 1'b0;
    chk("boot_exit_req", 32'(imem_req), 32'd1);
    chk("boot_exit_addr", imem_addr, 32'h0);
    chk("boot_ack_ignored_valid", 32'(instr_valid), 32'd0);

    // 2: zero-wait fetch and plain retire
    imem_ack = 1'b1;
    imem_rdata = 32'h2008_0005;
    instrQ.push_back(32'h2008_0005);
    tick();
    imem_ack = 1'b0;
    chk("t2_valid", 32'(instr_valid), 32'd1);
    popInstr("t2_instr");
    chk("t2_op", 32'(op), 32'h08);
    chk("t2_funct", 32'(funct), 32'h05);
    chk("t2_req_issue", 32'(imem_req), 32'd0);
    chk("t2_pc_plus4", pc_plus4, 32'h4);
    imem_ack = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    tick();
    imem_ack = 1'b0;
    chk("t2_issue_hold_instr", instr, 32'h2008_0005);
    ex_done = 1'b1;
    modelPc = 32'h4;
    modelInstret = 32'd1;
    pcQ.push_back(modelPc);
    tick();
    ex_done = 1'b0;
    popPc("t2_pc");
    chk("t2_instret", instret, 32'd1);
    chk("t2_req", 32'(imem_req), 32'd1);
    chk("t2_valid_low", 32'(instr_valid), 32'd0);

    // 3: three wait states with stray ex_done pulses during FETCH
    for (int i = 0; i < 3; i++) begin
      ex_done = 1'b1;
      chk("t3_req", 32'(imem_req), 32'd1);
      chk("t3_addr", imem_addr, 32'h4);
      tick();
      chk("t3_pc_hold", pc, 32'h4);
      chk("t3_instret_hold", instret, 32'd1);
      chk("t3_valid_low", 32'(instr_valid), 32'd0);
    end
    ex_done = 1'b0;
    chk("t3_req_last", 32'(imem_req), 32'd1);
    chk("t3_addr_last", imem_addr, 32'h4);
    imem_ack = 1'b1;
    imem_rdata = 32'h0000_0020;
    instrQ.push_back(32'h0000_0020);
    tick();
    imem_ack = 1'b0;
    chk("t3_valid", 32'(instr_valid), 32'd1);
    popInstr("t3_instr");
    ex_done = 1'b1;
    modelPc = 32'h8;
    modelInstret = 32'd2;
    pcQ.push_back(modelPc);
    tick();
    ex_done = 1'b0;
    popPc("t3_pc");

    // 4: branches around pc=0x10 with imm_ext=-2
    doInstr("walk_c", 32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    doInstr("walk_10", 32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("t4_at_10", pc, 32'h10);
    doInstr("beq_taken", 32'h1000_FFFE, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
    chk("t4_beq_taken", pc, 32'h0C);
    doInstr("walk_10b", 32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    doInstr("beq_nt", 32'h1000_FFFE, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE);
    chk("t4_beq_not_taken", pc, 32'h14);
    doInstr("bne_back", 32'h1400_FFFD, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFD);
    chk("t4_back_to_c", pc, 32'h0C);
    doInstr("walk_10c", 32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    doInstr("bne_taken", 32'h1400_FFFE, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE);
    chk("t4_bne_taken", pc, 32'h0C);

    // 5: jump outranks a simultaneously taken beq
    doInstr("jmp_setup", 32'h0810_0002, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("t5_at_400008", pc, 32'h0040_0008);
    doInstr("jmp_wins", 32'h0800_0100, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
    chk("t5_jump_wins", pc, 32'h0000_0400);

    // 6: asynchronous reset mid-FETCH, ack during BOOT ignored
    tick();
    chk("t6_fetch_wait_req", 32'(imem_req), 32'd1);
    rst_n = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("t6_async_pc", pc, 32'h0);
    chk("t6_async_req", 32'(imem_req), 32'd0);
    chk("t6_async_instret", instret, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("t6_boot_ack_ignored", 32'(instr_valid), 32'd0);
    chk("t6_instr_clear", instr, 32'd0);
    chk("t6_req", 32'(imem_req), 32'd1);
    chk("t6_addr", imem_addr, 32'h0);
    modelPc = 32'h0;
    modelInstret = 32'd0;
    doInstr("t6_restart", 32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("t6_restart_pc", pc, 32'h4);

    chk("scoreboard_drained", 32'(instrQ.size() + pcQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
    $finish;
  end

endmodule
